// File: rtl/nand_db.sv
// ----------------------------------------------------------------------------
// nand_db
//   Bitwise 2-input NAND primitive with an optional registered copy of the
//   result and a saturating change counter for debug visibility.
//
//   z is purely combinational and does not depend on clk, rst or en, so the
//   cell is usable with all side-band ports tied off. The registered path
//   captures ~(x & y) on enabled clock edges.
//
// Ports
//   clk      in   1      rising-edge clock for the registered side-band
//   rst      in   1      synchronous, active-high reset of the registered state
//   x        in   WIDTH  operand A
//   y        in   WIDTH  operand B
//   z        out  WIDTH  combinational result ~(x & y)
//   en       in   1      capture enable for z_q (tie to 0 when unused)
//   z_q      out  WIDTH  registered result (all ones after reset)
//   z_vld    out  1      z_q has captured at least one value since reset
//   chg_cnt  out  CNT_W  captures that changed z_q; saturates at all ones
// ----------------------------------------------------------------------------
module nand_db #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    input  logic             en,
    output logic [WIDTH-1:0] z_q,
    output logic             z_vld,
    output logic [CNT_W-1:0] chg_cnt
);

    // Increment that sticks at the maximum count instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    assign z = ~(x & y);

    // Registered side-band. The reset value of z_q is all ones (NAND of zero
    // operands), so a first capture of x=y=all ones registers as a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q     <= {WIDTH{1'b1}};
            z_vld   <= 1'b0;
            chg_cnt <= '0;
        end else if (en) begin
            z_q   <= z;
            z_vld <= 1'b1;
            if (z != z_q) begin
                chg_cnt <= sat_inc(chg_cnt);
            end
        end
    end

endmodule

// File: tb/tb_nand_db.sv
// ----------------------------------------------------------------------------
// tb_nand_db
//   Self-checking bench for nand_db. Two instances: a 4-lane one with the
//   default 8-bit counter driven randomly, and a 1-lane one with a 2-bit
//   counter driven through the directed scenarios and saturation.
// ----------------------------------------------------------------------------
module tb_nand_db;

    localparam int WA = 4;
    localparam int CA = 8;
    localparam int WB = 1;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          clk_run = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;

    logic [WA-1:0] x_a = '0, y_a = '0;
    logic [WA-1:0] z_a, z_q_a;
    logic          z_vld_a;
    logic [CA-1:0] chg_cnt_a;

    logic [WB-1:0] x_b = '0, y_b = '0;
    logic [WB-1:0] z_b, z_q_b;
    logic          z_vld_b;
    logic [CB-1:0] chg_cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state, kept as plain integers/vectors.
    int            ma_zq, ma_cnt, mb_zq, mb_cnt;
    bit            ma_vld, mb_vld;

    nand_db #(.WIDTH(WA), .CNT_W(CA)) dut_a (
        .clk(clk), .rst(rst), .x(x_a), .y(y_a), .z(z_a), .en(en),
        .z_q(z_q_a), .z_vld(z_vld_a), .chg_cnt(chg_cnt_a)
    );

    nand_db #(.WIDTH(WB), .CNT_W(CB)) dut_b (
        .clk(clk), .rst(rst), .x(x_b), .y(y_b), .z(z_b), .en(en),
        .z_q(z_q_b), .z_vld(z_vld_b), .chg_cnt(chg_cnt_b)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-lane truth table: only 1,1 gives 0.
    function automatic int nand_ref(input int a, input int b, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            if (!(((a >> i) & 1) == 1 && ((b >> i) & 1) == 1)) r |= (1 << i);
        end
        return r;
    endfunction

    task automatic model_edge(input bit r, input bit e, input int xv, input int yv,
                              input int w, input int cmax,
                              inout int zq, inout bit vld, inout int cnt);
        int nz;
        if (r) begin
            zq  = (1 << w) - 1;
            vld = 1'b0;
            cnt = 0;
        end else if (e) begin
            nz = nand_ref(xv, yv, w);
            if (nz != zq && cnt < cmax) cnt = cnt + 1;
            zq  = nz;
            vld = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".z_a"},   32'(z_a),       32'(nand_ref(int'(x_a), int'(y_a), WA)));
        chk({tag, ".zq_a"},  32'(z_q_a),     32'(ma_zq));
        chk({tag, ".vld_a"}, 32'(z_vld_a),   32'(ma_vld));
        chk({tag, ".cnt_a"}, 32'(chg_cnt_a), 32'(ma_cnt));
        chk({tag, ".z_b"},   32'(z_b),       32'(nand_ref(int'(x_b), int'(y_b), WB)));
        chk({tag, ".zq_b"},  32'(z_q_b),     32'(mb_zq));
        chk({tag, ".vld_b"}, 32'(z_vld_b),   32'(mb_vld));
        chk({tag, ".cnt_b"}, 32'(chg_cnt_b), 32'(mb_cnt));
    endtask

    // Drive inputs away from the edge, clock once, update model, sample #1 later.
    task automatic cycle(input string tag, input bit r, input bit e,
                         input int xa, input int ya, input int xb, input int yb);
        rst = r;
        en  = e;
        x_a = WA'(xa);
        y_a = WA'(ya);
        x_b = WB'(xb);
        y_b = WB'(yb);
        @(posedge clk);
        model_edge(r, e, xa & 'hF, ya & 'hF, WA, (1 << CA) - 1, ma_zq, ma_vld, ma_cnt);
        model_edge(r, e, xb & 1, yb & 1, WB, (1 << CB) - 1, mb_zq, mb_vld, mb_cnt);
        #1;
        check_all(tag);
    endtask

    initial begin
        int xa, ya, xb, yb;
        bit r, e;

        // Combinational sweep with the clock stopped.
        for (int i = 0; i < 4; i++) begin
            x_b = WB'((i >> 1) & 1);
            y_b = WB'(i & 1);
            x_a = WA'($urandom);
            y_a = WA'($urandom);
            #10;
            chk("sweep.z_b", 32'(z_b), (i == 3) ? 32'd0 : 32'd1);
            chk("sweep.z_a", 32'(z_a), 32'(nand_ref(int'(x_a), int'(y_a), WA)));
        end

        clk_run = 1'b1;

        // Reset, with inputs still moving so z is seen to follow them.
        cycle("reset", 1, 0, 'hC, 'hA, 1, 0);
        chk("reset.zq_b_const", 32'(z_q_b), 32'd1);
        chk("reset.vld_b_const", 32'(z_vld_b), 32'd0);
        cycle("reset2", 1, 0, 'h3, 'hF, 1, 1);

        // Capture: first x=y=1 counts against the all-ones reset value.
        cycle("cap1", 0, 1, 'hF, 'hF, 1, 1);
        chk("cap1.cnt_b_const", 32'(chg_cnt_b), 32'd1);
        chk("cap1.zq_b_const", 32'(z_q_b), 32'd0);
        cycle("cap2", 0, 1, 'h0, 'hF, 0, 1);
        chk("cap2.cnt_b_const", 32'(chg_cnt_b), 32'd2);

        // Hold: en low, inputs toggling.
        for (int i = 0; i < 5; i++) begin
            cycle("hold", 0, 0, int'($urandom), int'($urandom), i & 1, (i >> 1) & 1);
        end
        chk("hold.cnt_b_const", 32'(chg_cnt_b), 32'd2);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 6; i++) begin
            cycle("sat", 0, 1, (i & 1) ? 'h0 : 'hF, 'hF, (i + 1) & 1, 1);
        end
        chk("sat.cnt_b_const", 32'(chg_cnt_b), 32'd3);

        // Reset beats enable on the same edge.
        cycle("prio", 1, 1, 'hF, 'hF, 1, 1);
        chk("prio.zq_b_const", 32'(z_q_b), 32'd1);
        chk("prio.cnt_b_const", 32'(chg_cnt_b), 32'd0);
        chk("prio.vld_b_const", 32'(z_vld_b), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            e  = ($urandom_range(0, 2) != 0);
            xa = int'($urandom_range(0, 15));
            ya = int'($urandom_range(0, 15));
            xb = int'($urandom_range(0, 1));
            yb = int'($urandom_range(0, 1));
            cycle("rand", r, e, xa, ya, xb, yb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nand_db.md
Name: nand_db

Overview:
- Bitwise 2-input NAND cell used as a primitive logic element.
- Output z is purely combinational: z = ~(x & y), with no clock dependency.
- Optional registered copy of the result, plus a change counter for observability/debug.
- Sits at leaf level; instantiated wherever a NAND term is needed, with the side-band ports left unconnected when only z is used.

Parameters:
- WIDTH, 1, bit width of x, y, z and z_q (bitwise operation per lane).
- CNT_W, 8, width of the z_q change counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- z  output  WIDTH  combinational NAND result, ~(x & y).
- en  input  1  capture enable for z_q; tie-off value 0.
- z_q  output  WIDTH  registered NAND result.
- z_vld  output  1  z_q holds at least one captured value since reset.
- chg_cnt  output  CNT_W  number of captures where z_q changed value; saturates.

Behaviour:
- Combinational path:
  - z[i] = ~(x[i] & y[i]) for every lane i.
  - Zero-cycle latency; independent of clk, rst and en.
  - Valid with clk/rst/en unconnected.
  - Truth table per lane: 00->1, 01->1, 10->1, 11->0.
- Reset (synchronous, sampled at rising clk while rst=1):
  - z_q <= all ones (NAND of zero operands).
  - z_vld <= 0.
  - chg_cnt <= 0.
  - z is unaffected by reset.
- Capture (rising clk, rst=0, en=1):
  - z_q <= ~(x & y).
  - z_vld <= 1.
  - If the new value differs from the current z_q in any lane, chg_cnt <= chg_cnt + 1.
- Hold: with en=0 and rst=0, z_q, z_vld and chg_cnt hold their values.
- Priority: rst overrides en in the same cycle.
- Saturation: chg_cnt holds at 2^CNT_W-1 and does not wrap.
- First capture after reset:
  - Compared against the reset value (all ones).
  - x=y=all ones therefore counts as a change.
- Reset mid-operation clears only the registered state; z keeps tracking inputs continuously.
- No X propagation from unconnected side-band ports onto z.

Decomposition:
- No shared package required.
- Single flat module; no sub-module is warranted.
- The saturating counter may be an inline always block.

Test Plan:
- Combinational sweep, WIDTH=1, 10 ns steps: (x,y)=00 -> z=1; 01 -> z=1; 10 -> z=1; 11 -> z=0. No clock running, z settles within the same delta.
- Reset: rst=1 for one clk edge -> z_q=1, z_vld=0, chg_cnt=0. z still follows inputs during reset.
- Capture: rst=0, en=1, x=1, y=1 at an edge -> z_q=0, z_vld=1, chg_cnt=1. Then x=0 -> z_q=1, chg_cnt=2.
- Hold: en=0, toggle x,y over 5 edges -> z_q, z_vld and chg_cnt unchanged while z tracks inputs.
- Saturation, CNT_W=2: alternate x between 1 and 0 with y=1, en=1, over 6 edges -> chg_cnt reaches 3 and stays 3.
- Priority: rst=1 and en=1 on the same edge with x=y=1 -> z_q=1, chg_cnt=0, z_vld=0.
